booth_seq_ctrl: RTL and testbench

- Sequential controller for a radix-2 Booth signed multiplier, 8 bit × 8 bit → 16 bit.
- Accepts an operand pair on a start handshake, then issues one Booth add/sub-and-arithmetic-shift step per clock for 8 cycles.
- Registers the 16-bit product and signals completion with a one-cycle `done` pulse.
- Sits between the issue logic and the register file, and replaces the chained, unrolled combinational `booth` steps with a single time-multiplexed step.

---
 rtl/booth_seq_ctrl.sv | 115 +++++++++++
 tb/tb_booth_seq_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth signed multiplier controller, N x N -> 2N, one step per clock.
// Optional abort input enabled by defining BOOTH_SEQ_ABORT_EN.
module booth_seq_ctrl #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N-1:0]        multiplicand,
    input  logic [N-1:0]        multiplier,
`ifdef BOOTH_SEQ_ABORT_EN
    input  logic                abort,
`endif
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [2*N-1:0]      product
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic signed [N:0]    acc;
    logic        [N:0]    q;
    logic signed [N:0]    m;
    logic        [CW-1:0] cnt;

    logic signed [N:0]    acc_nxt;
    logic        [N:0]    q_nxt;
    logic [2*N+1:0]       step;
    logic                 abort_req;
    logic                 accept;
    logic                 advance;
    logic                 last;

    // One Booth step: add/sub selected by q[1:0], then arithmetic shift of {acc, q}.
    function automatic logic [2*N+1:0] booth_step(input logic signed [N:0] a,
                                                  input logic        [N:0] qq,
                                                  input logic signed [N:0] mm);
        logic signed [N:0] t;
        case (qq[1:0])
            2'b01:   t = a + mm;
            2'b10:   t = a - mm;
            default: t = a;
        endcase
        return {t[N], t[N:1], t[0], qq[N:1]};
    endfunction

`ifdef BOOTH_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign step    = booth_step(acc, q, m);
    assign acc_nxt = step[2*N+1:N+1];
    assign q_nxt   = step[N:0];

    assign accept  = start && (state != RUN);
    assign advance = (state == RUN) && !abort_req;
    assign last    = advance && (cnt == CW'(N - 1));

    assign ready = (state != RUN);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (abort_req)
                    state_nxt = IDLE;
                else if (cnt == CW'(N - 1))
                    state_nxt = DONE;
            end
            DONE: state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc <= '0;
                q   <= {multiplier, 1'b0};
                m   <= {multiplicand[N-1], multiplicand};
                cnt <= '0;
            end else if (advance) begin
                acc <= acc_nxt;
                q   <= q_nxt;
                cnt <= cnt + CW'(1);
            end
            // Product is captured from the post-shift values of the final step.
            if (last)
                product <= {acc_nxt[N-1:0], q_nxt[N:1]};
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl: signed products, back-to-back, ignored start, reset and abort.
module tb_booth_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] product;
`ifdef BOOTH_SEQ_ABORT_EN
    logic        abort;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    booth_seq_ctrl #(.N(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
`ifdef BOOTH_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, then check the 8 RUN cycles and the DONE cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input logic [15:0] prev, input string tag);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_val({tag, "_busy"}, busy, 1'b1);
            check_val({tag, "_nodone"}, done, 1'b0);
            check_val({tag, "_hold"}, product, prev);
            tick();
        end
        check_val({tag, "_done"}, done, 1'b1);
        check_val({tag, "_ready"}, ready, 1'b1);
        check_val({tag, "_prod"}, product, exp);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
`ifdef BOOTH_SEQ_ABORT_EN
        abort        = 1'b0;
`endif
        tick();
        tick();
        check_val("rst_ready", ready, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_prod", product, 16'h0000);
        rst_n = 1'b1;
        tick();
        check_val("idle_ready", ready, 1'b1);

        run_op(8'd3, 8'd4, 16'h000C, 16'h0000, "3x4");
        tick();
        check_val("3x4_pulse", done, 1'b0);
        check_val("3x4_keep", product, 16'h000C);

        run_op(8'h80, 8'h80, 16'h4000, 16'h000C, "m128xm128");
        tick();
        run_op(8'h80, 8'h7F, 16'hC080, 16'h4000, "m128x127");
        tick();
        run_op(8'hFF, 8'hFF, 16'h0001, 16'hC080, "m1xm1");
        tick();
        run_op(8'h00, 8'hB3, 16'h0000, 16'h0001, "0xm77");
        tick();

        // Back-to-back: start held in DONE launches the next operation immediately.
        run_op(8'd3, 8'd4, 16'h000C, 16'h0000, "b2b_a");
        run_op(8'd5, 8'hFD, 16'hFFF1, 16'h000C, "b2b_b");
        tick();
        check_val("b2b_idle", done, 1'b0);

        // A start during RUN with different operands must be ignored.
        multiplicand = 8'd7;
        multiplier   = 8'hF7;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_val("ign_busy", busy, 1'b1);
            start        = (i == 3);
            multiplicand = (i == 3) ? 8'd2 : 8'd7;
            multiplier   = (i == 3) ? 8'd2 : 8'hF7;
            tick();
        end
        start = 1'b0;
        check_val("ign_done", done, 1'b1);
        check_val("ign_prod", product, 16'hFFC1);
        tick();
        check_val("ign_idle", ready, 1'b1);

`ifdef BOOTH_SEQ_ABORT_EN
        run_op(8'd7, 8'd7, 16'h0031, 16'hFFC1, "7x7");
        tick();
        multiplicand = 8'd7;
        multiplier   = 8'd7;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abt_ready", ready, 1'b1);
        check_val("abt_busy", busy, 1'b0);
        check_val("abt_prod", product, 16'h0031);
        for (int i = 0; i < 8; i++) begin
            check_val("abt_nodone", done, 1'b0);
            tick();
        end
        check_val("abt_keep", product, 16'h0031);
`endif

        // Reset during RUN: next edge returns to IDLE with product cleared.
        multiplicand = 8'd3;
        multiplier   = 8'd4;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_val("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        check_val("mid_ready", ready, 1'b1);
        check_val("mid_busy0", busy, 1'b0);
        check_val("mid_done", done, 1'b0);
        check_val("mid_prod", product, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_val("mid_nodone", done, 1'b0);
            tick();
        end

        // Reset wins over start in the same cycle.
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        rst_n = 1'b1;
        check_val("rst_win", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
